// File: rtl/key_uart_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_uart_sender: merges PS/2 scancodes and switch bytes into one FIFO and  |
// | drains it to a UART transmitter with an optional break-code filter.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module key_uart_sender #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 8,
  parameter int FILTER_BREAK = 1,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          code_in,
  input  logic                       code_valid,
  input  logic [DATA_W-1:0]          sw_data,
  input  logic                       sw_send,
  input  logic                       clr_ovf,
  input  logic                       tx_busy,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          last_key,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
  localparam logic [TW-1:0]     TO_LAST    = TW'(BUSY_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] BREAK_CODE = DATA_W'(8'hF0);
  localparam bit                FILTER_EN  = (FILTER_BREAK != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                skip_q, skip_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   last_key_q, last_key_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                kb_req;
  logic                sw_req;
  logic [DATA_W-1:0]   sw_byte;
  logic                wr_req;
  logic [DATA_W-1:0]   wr_byte;
  logic                wr_ok;
  logic                pop;

  always_comb begin
    kb_req  = code_valid && !(FILTER_EN && (skip_q || code_in == BREAK_CODE));
    skip_d  = skip_q;
    if (FILTER_EN && code_valid) begin
      skip_d = !skip_q && (code_in == BREAK_CODE);
    end

    // A fresh switch strobe supersedes a byte still waiting for a free slot.
    sw_req  = sw_send || pend_q;
    sw_byte = sw_send ? sw_data : pend_data_q;

    pop     = (state_q == S_IDLE) && (count_q != '0) && !tx_busy;
    wr_req  = kb_req || sw_req;
    wr_byte = kb_req ? code_in : sw_byte;
    wr_ok   = wr_req && ((count_q != DEPTH_C) || pop);

    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    if (kb_req) begin
      if (sw_req) begin
        pend_d      = 1'b1;
        pend_data_d = sw_byte;
      end
    end else if (sw_req) begin
      pend_d = 1'b0;
    end

    ovf_d = ovf_q;
    if (wr_req && !wr_ok) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    last_key_d = (kb_req && wr_ok) ? code_in : last_key_q;
    wr_ptr_d   = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

    unique case ({wr_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    timer_d   = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // A uart that never acknowledges must not stall the queue forever.
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end else if (timer_q == TO_LAST) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      skip_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      ovf_q       <= 1'b0;
      last_key_q  <= '0;
      tx_data_q   <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      skip_q      <= skip_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      ovf_q       <= ovf_d;
      last_key_q  <= last_key_d;
      tx_data_q   <= tx_data_d;
      timer_q     <= timer_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_byte;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = (state_q == S_START);
  assign last_key   = last_key_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire
